imem_boot_ctrl: RTL

- Loads a program into the core's instruction memory from an 8-bit byte stream, then runs the core and supervises it.
- Releases the core from reset, counts run cycles, and stops on a core halt or a watchdog timeout.
- Sits between the external load port and the `top` core and its instruction memory.
- Makes program loading a synthesizable, handshaked path that supports any instruction width and memory depth.

---
 rtl/imem_boot_ctrl_if.sv | 23 ++
 rtl/imem_boot_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_ctrl_if.sv
// Byte-stream load port and instruction-memory write port of the boot controller.
// The slave modport is the controller; the master modport is the stream source / memory side.
interface imem_boot_ctrl_if #(
  parameter int IW = 32,
  parameter int AW = 4
);
  logic          s_valid;
  logic [7:0]    s_data;
  logic          s_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [IW-1:0] mem_wdata;

  modport master (
    output s_valid, s_data,
    input  s_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  s_valid, s_data,
    output s_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_boot_ctrl.sv
// Boot controller: assembles a little-endian byte stream into instruction words,
// writes them to instruction memory, then releases the core and supervises its run.
module imem_boot_ctrl #(
  parameter int IW      = 32,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 1024,
  parameter int AW      = $clog2(DEPTH),
  parameter int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  imem_boot_ctrl_if.slave bus,
  input  logic          i_start,
  input  logic [AW:0]   i_len,
  input  logic          i_halt,
  output logic          o_core_rst,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_timed_out,
  output logic          o_err,
  output logic [CW-1:0] o_cycles
);

  localparam int BPW = IW / 8;
  localparam int BW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int LW  = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_COMMIT,
    S_RUN,
    S_DONE
  } state_t;

  state_t        r_state,     w_state;
  logic          r_s_ready,   w_s_ready;
  logic          r_mem_we,    w_mem_we;
  logic [AW-1:0] r_mem_addr,  w_mem_addr;
  logic [IW-1:0] r_mem_wdata, w_mem_wdata;
  logic          r_core_rst,  w_core_rst;
  logic          r_busy,      w_busy;
  logic          r_done,      w_done;
  logic          r_timed_out, w_timed_out;
  logic          r_err,       w_err;
  logic [CW-1:0] r_cycles,    w_cycles;
  logic [LW-1:0] r_len,       w_len;
  logic [LW-1:0] r_word_idx,  w_word_idx;
  logic [BW-1:0] r_byte_idx,  w_byte_idx;
  logic [IW-1:0] r_word,      w_word;

  logic          w_accept;
  logic          w_bad_len;
  logic [IW-1:0] w_asm;

  assign w_accept  = r_s_ready && bus.s_valid;
  assign w_bad_len = (i_len == '0) || (i_len > LW'(DEPTH));

  // Partial word with the incoming byte dropped into its little-endian lane.
  always_comb begin
    w_asm = r_word;
    w_asm[int'(r_byte_idx) * 8 +: 8] = bus.s_data;
  end

  always_comb begin
    w_state     = r_state;
    w_s_ready   = r_s_ready;
    w_mem_we    = 1'b0;
    w_mem_addr  = r_mem_addr;
    w_mem_wdata = r_mem_wdata;
    w_core_rst  = r_core_rst;
    w_busy      = r_busy;
    w_done      = 1'b0;
    w_timed_out = r_timed_out;
    w_err       = r_err;
    w_cycles    = r_cycles;
    w_len       = r_len;
    w_word_idx  = r_word_idx;
    w_byte_idx  = r_byte_idx;
    w_word      = r_word;

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_err       = 1'b0;
          w_timed_out = 1'b0;
          w_cycles    = '0;
          if (w_bad_len) begin
            w_err = 1'b1;
          end else begin
            w_len      = i_len;
            w_word_idx = '0;
            w_byte_idx = '0;
            w_word     = '0;
            w_s_ready  = 1'b1;
            w_busy     = 1'b1;
            w_state    = S_LOAD;
          end
        end
      end

      S_LOAD: begin
        if (w_accept) begin
          if (r_byte_idx == BW'(BPW - 1)) begin
            w_mem_we    = 1'b1;
            w_mem_addr  = r_word_idx[AW-1:0];
            w_mem_wdata = w_asm;
            w_word_idx  = r_word_idx + LW'(1);
            w_byte_idx  = '0;
            w_word      = '0;
            // Ready drops on the same edge so no byte beyond the last word is taken.
            if ((r_word_idx + LW'(1)) == r_len) begin
              w_s_ready = 1'b0;
              w_state   = S_COMMIT;
            end
          end else begin
            w_word     = w_asm;
            w_byte_idx = r_byte_idx + BW'(1);
          end
        end
      end

      S_COMMIT: begin
        w_core_rst = 1'b0;
        w_state    = S_RUN;
      end

      S_RUN: begin
        // Halt takes priority over a watchdog expiry in the same cycle.
        if (i_halt) begin
          w_core_rst = 1'b1;
          w_done     = 1'b1;
          w_state    = S_DONE;
        end else if (r_cycles == CW'(TIMEOUT - 1)) begin
          w_timed_out = 1'b1;
          w_core_rst  = 1'b1;
          w_done      = 1'b1;
          w_state     = S_DONE;
        end else begin
          w_cycles = r_cycles + CW'(1);
        end
      end

      S_DONE: begin
        w_busy  = 1'b0;
        w_state = S_IDLE;
      end

      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_s_ready   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_core_rst  <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_timed_out <= 1'b0;
      r_err       <= 1'b0;
      r_cycles    <= '0;
      r_len       <= '0;
      r_word_idx  <= '0;
      r_byte_idx  <= '0;
      r_word      <= '0;
    end else begin
      r_state     <= w_state;
      r_s_ready   <= w_s_ready;
      r_mem_we    <= w_mem_we;
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
      r_core_rst  <= w_core_rst;
      r_busy      <= w_busy;
      r_done      <= w_done;
      r_timed_out <= w_timed_out;
      r_err       <= w_err;
      r_cycles    <= w_cycles;
      r_len       <= w_len;
      r_word_idx  <= w_word_idx;
      r_byte_idx  <= w_byte_idx;
      r_word      <= w_word;
    end
  end

  assign bus.s_ready   = r_s_ready;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign o_core_rst    = r_core_rst;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_timed_out   = r_timed_out;
  assign o_err         = r_err;
  assign o_cycles      = r_cycles;

endmodule
